// File: rtl/inv_shift_sub_iter_if.sv
// Handshake bundle for the iterative InvShiftRows/InvSubBytes stage.
// The master side feeds states in and drains results; the slave side is the stage itself.
interface inv_shift_sub_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state,
    output busy
  );
endinterface

// File: rtl/inv_shift_sub_iter.sv
// Iterative AES decrypt InvShiftRows + InvSubBytes stage feeding InvMixColumns.
// The state is row-shifted on capture, then BPC bytes per cycle pass through BPC shared inverse S-boxes.
module inv_shift_sub_iter #(
  parameter int BPC = 4
) (
  input logic                 clk,
  input logic                 rst,
  inv_shift_sub_iter_if.slave bus
);
  localparam int NCYC = 16 / BPC;
  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [CW-1:0] cnt;
  logic [127:0]  dataBuf;
  logic [127:0]  subBuf;
  logic          capture;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse for nonzero a and conveniently maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = a;
    for (int i = 1; i < 8; i++) begin
      base = gfMul(base, base);
      res  = gfMul(res, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gfInv(t);
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] d);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = d[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  assign capture       = (state == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_state = dataBuf;

  // The byte window selected by cnt is routed through the BPC shared S-boxes
  always_comb begin
    subBuf = dataBuf;
    for (int j = 0; j < BPC; j++) begin
      subBuf[127-8*(BPC*int'(cnt)+j) -: 8] = invSbox(dataBuf[127-8*(BPC*int'(cnt)+j) -: 8]);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (capture) stateNext = BUSY;
      BUSY:    if (cnt == LAST) stateNext = DONE;
      DONE:    if (bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // cnt wraps at LAST so the byte window never leaves the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dataBuf <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (capture) begin
            dataBuf <= invShiftRows(bus.in_state);
            cnt     <= '0;
          end
        end
        BUSY: begin
          dataBuf <= subBuf;
          cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_shift_sub_iter.sv
// Bench for inv_shift_sub_iter at BPC = 1, 4 and 16 against FIPS-197 vectors and a table-based model.
// The model builds the forward S-box from field arithmetic and inverts it by lookup.
module tb_inv_shift_sub_iter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inv_shift_sub_iter_if ifc1 ();
  inv_shift_sub_iter_if ifc4 ();
  inv_shift_sub_iter_if ifc16 ();

  inv_shift_sub_iter #(.BPC(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1));
  inv_shift_sub_iter #(.BPC(4))  dut4  (.clk(clk), .rst(rst), .bus(ifc4));
  inv_shift_sub_iter #(.BPC(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));

  logic         inValid [3];
  logic [127:0] inState [3];
  logic         outReady [3];
  logic         inReadyW [3];
  logic         outValidW [3];
  logic         busyW [3];
  logic [127:0] outStateW [3];

  assign ifc1.in_valid   = inValid[0];
  assign ifc1.in_state   = inState[0];
  assign ifc1.out_ready  = outReady[0];
  assign inReadyW[0]     = ifc1.in_ready;
  assign outValidW[0]    = ifc1.out_valid;
  assign busyW[0]        = ifc1.busy;
  assign outStateW[0]    = ifc1.out_state;
  assign ifc4.in_valid   = inValid[1];
  assign ifc4.in_state   = inState[1];
  assign ifc4.out_ready  = outReady[1];
  assign inReadyW[1]     = ifc4.in_ready;
  assign outValidW[1]    = ifc4.out_valid;
  assign busyW[1]        = ifc4.busy;
  assign outStateW[1]    = ifc4.out_state;
  assign ifc16.in_valid  = inValid[2];
  assign ifc16.in_state  = inState[2];
  assign ifc16.out_ready = outReady[2];
  assign inReadyW[2]     = ifc16.in_ready;
  assign outValidW[2]    = ifc16.out_valid;
  assign busyW[2]        = ifc16.busy;
  assign outStateW[2]    = ifc16.out_state;

  int assertions = 0;
  int failures = 0;
  int lat [3] = '{16, 4, 1};
  int bpcOf [3] = '{1, 4, 16};
  logic [7:0] invSboxTab [256];

  typedef struct packed {
    logic [127:0] inData;
    logic [127:0] expData;
  } vecT;

  vecT vecs [3];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box = affine(inverse); its inverse table is filled by reverse lookup
  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      invSboxTab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] refModel(input logic [127:0] d);
    logic [7:0] m [4][4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) m[i % 4][i / 4] = d[127-8*i -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = invSboxTab[m[r][(c - r + 4) % 4]];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic applyStimulus(input int s, input logic [127:0] d);
    inState[s] = d;
    inValid[s] = 1'b1;
    @(posedge clk); #1;
    inValid[s] = 1'b0;
    inState[s] = rand128();
  endtask

  task automatic waitValid(input int s, output int n);
    n = 0;
    while (!outValidW[s] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handoff(input int s, input string tag);
    outReady[s] = 1'b1;
    @(posedge clk); #1;
    outReady[s] = 1'b0;
    inValid[s] = 1'b0;
    checkOutput({tag, " handoff valid/ready/busy"}, {outValidW[s], inReadyW[s], busyW[s]}, 3'b010);
  endtask

  task automatic runVector(input int s, input logic [127:0] d, input logic [127:0] exp, input string tag);
    int n;
    checkOutput({tag, " inReady before"}, inReadyW[s], 1);
    applyStimulus(s, d);
    waitValid(s, n);
    checkOutput({tag, " latency"}, n, lat[s]);
    checkOutput({tag, " outState"}, outStateW[s], exp);
    checkOutput({tag, " busy in DONE"}, busyW[s], 1);
    handoff(s, tag);
  endtask

  initial begin
    int n;
    logic [127:0] d;
    logic [127:0] e;
    buildTables();
    vecs[0] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vecs[1] = '{128'h0, {16{8'h52}}};
    vecs[2] = '{{16{8'h63}}, 128'h0};
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      inValid[s] = 1'b0;
      inState[s] = rand128();
      outReady[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("BPC%0d reset inReady", bpcOf[s]), inReadyW[s], 1);
      checkOutput($sformatf("BPC%0d reset outValid", bpcOf[s]), outValidW[s], 0);
      checkOutput($sformatf("BPC%0d reset busy", bpcOf[s]), busyW[s], 0);
      checkOutput($sformatf("BPC%0d reset outState", bpcOf[s]), outStateW[s], 0);
    end

    // FIPS and corner vectors at every BPC
    for (int s = 0; s < 3; s++)
      for (int v = 0; v < 3; v++)
        runVector(s, vecs[v].inData, vecs[v].expData, $sformatf("BPC%0d vec%0d", bpcOf[s], v));

    // Backpressure in DONE with a competing in_valid that must be ignored
    d = rand128();
    applyStimulus(1, d);
    waitValid(1, n);
    checkOutput("bp latency", n, 4);
    inValid[1] = 1'b1;
    inState[1] = rand128();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp outState held", outStateW[1], refModel(d));
      checkOutput("bp valid/ready/busy", {outValidW[1], inReadyW[1], busyW[1]}, 3'b101);
    end
    handoff(1, "bp");

    // in_valid held through BUSY with a changing in_state
    d = rand128();
    inState[1] = d;
    inValid[1] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!outValidW[1] && n < 40) begin
      inState[1] = rand128();
      @(posedge clk); #1;
      n++;
    end
    inValid[1] = 1'b0;
    checkOutput("hold latency", n, 4);
    checkOutput("hold outState", outStateW[1], refModel(d));
    handoff(1, "hold");

    // Reset mid-BUSY at cnt=2 discards the state
    applyStimulus(1, rand128());
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset valid/ready/busy", {outValidW[1], inReadyW[1], busyW[1]}, 3'b010);
    checkOutput("midreset outState", outStateW[1], 0);
    d = rand128();
    runVector(1, d, refModel(d), "post-reset");

    // Random states against the model
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < ((s == 1) ? 1000 : 100); k++) begin
        d = rand128();
        e = refModel(d);
        runVector(s, d, e, $sformatf("BPC%0d rand%0d", bpcOf[s], k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
